// File: rtl/ahb_pkg.sv
// Shared AHB encodings, master-count default and index helpers for the
// arbiter slice.
package ahb_pkg;

    localparam int AHB_NUM_MST = 3;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef logic [1:0] mst_idx_t;

    // Next master index after idx, wrapping modulo n (n is 2..4).
    function automatic mst_idx_t idx_inc(input mst_idx_t idx, input int n);
        logic [2:0] s;
        s = {1'b0, idx} + 3'd1;
        if (s >= 3'(n)) begin
            s = 3'd0;
        end
        return s[1:0];
    endfunction

    function automatic logic is_retry_split(input logic [1:0] resp);
        return (resp == HRESP_RETRY) || (resp == HRESP_SPLIT);
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin search: first set bit of i_req at or after
// i_start, wrapping modulo NUM_MST.
module ahb_rr_picker
    import ahb_pkg::*;
#(
    parameter int NUM_MST = AHB_NUM_MST
) (
    input  logic [NUM_MST-1:0] i_req,
    input  mst_idx_t           i_start,
    output logic               o_found,
    output mst_idx_t           o_idx
);

    localparam logic [NUM_MST-1:0] REQ_ONE = {{(NUM_MST-1){1'b0}}, 1'b1};

    logic [NUM_MST-1:0] w_hit;
    mst_idx_t           w_cand [NUM_MST];

    // Candidate gi is the master gi positions after the start index.
    generate
        for (genvar gi = 0; gi < NUM_MST; gi++) begin : g_cand
            logic [2:0] w_sum;
            assign w_sum         = {1'b0, i_start} + 3'(gi);
            assign w_cand[gi]    = (w_sum >= 3'(NUM_MST)) ? 2'(w_sum - 3'(NUM_MST))
                                                          : w_sum[1:0];
            assign w_hit[gi]     = |(i_req & (REQ_ONE << w_cand[gi]));
        end
    endgenerate

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = NUM_MST - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                o_found = 1'b1;
                o_idx   = w_cand[k];
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant with parking, tenure limit, RETRY/SPLIT
// handover and pipelined address/data-phase owner outputs.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MST     = AHB_NUM_MST,
    parameter int DEFAULT_MST = 0,
    parameter int MAX_TENURE  = 16
) (
    input  logic               hclk,
    input  logic               hresetn,
    input  logic [NUM_MST-1:0] hbusreq,
    input  logic               hready,
    input  logic [1:0]         hresp,
    output logic [NUM_MST-1:0] hgrant,
    output logic [1:0]         hmaster,
    output logic [1:0]         hmaster_data
);

    localparam int TW = $clog2(MAX_TENURE + 1);
    localparam logic [TW-1:0] TEN_MAX  = TW'(MAX_TENURE);
    localparam logic [TW-1:0] TEN_LAST = TW'(MAX_TENURE - 1);

    localparam mst_idx_t DEF_IDX    = 2'(DEFAULT_MST);
    localparam mst_idx_t PARK_START = idx_inc(DEF_IDX, NUM_MST);

    localparam logic [NUM_MST-1:0] GRANT_ONE = {{(NUM_MST-1){1'b0}}, 1'b1};
    localparam logic [NUM_MST-1:0] GRANT_DEF = GRANT_ONE << DEF_IDX;

    localparam logic [0:0] ST_PARK = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    logic [0:0]         r_state;
    logic [NUM_MST-1:0] r_grant;
    mst_idx_t           r_rr_ptr;
    logic [TW-1:0]      r_tenure;
    mst_idx_t           r_hmaster;
    mst_idx_t           r_hmaster_data;

    logic [0:0]         w_state_next;
    logic [NUM_MST-1:0] w_grant_next;
    mst_idx_t           w_ptr_next;
    logic [TW-1:0]      w_tenure_next;

    logic [NUM_MST-1:0] w_owner_mask;
    logic               w_owner_req;
    logic               w_others_req;
    logic               w_retry;
    logic               w_tenure_hit;
    logic               w_rearb;
    logic [NUM_MST-1:0] w_pick_req;
    mst_idx_t           w_pick_start;
    logic               w_pick_found;
    mst_idx_t           w_pick_idx;
    mst_idx_t           w_grant_idx;

    // In OWN the pointer always names the current owner.
    assign w_owner_mask = GRANT_ONE << r_rr_ptr;
    assign w_owner_req  = |(hbusreq & w_owner_mask);
    assign w_others_req = |(hbusreq & ~w_owner_mask);
    assign w_retry      = is_retry_split(hresp);

    // The limit triggers on the edge that completes MAX_TENURE owned edges.
    assign w_tenure_hit = (r_tenure >= TEN_LAST);
    assign w_rearb      = !w_owner_req || (w_tenure_hit && w_others_req) || w_retry;

    // The owner is masked out during re-arbitration: it can only be kept by
    // not re-arbitrating at all, or re-granted after a PARK cycle.
    assign w_pick_req   = (r_state == ST_PARK) ? hbusreq : (hbusreq & ~w_owner_mask);
    assign w_pick_start = (r_state == ST_PARK) ? PARK_START : idx_inc(r_rr_ptr, NUM_MST);

    ahb_rr_picker #(
        .NUM_MST (NUM_MST)
    ) u_picker (
        .i_req   (w_pick_req),
        .i_start (w_pick_start),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (r_grant[i]) begin
                w_grant_idx = 2'(i);
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_grant_next  = r_grant;
        w_ptr_next    = r_rr_ptr;
        w_tenure_next = r_tenure;
        if ((r_state == ST_PARK) || w_rearb) begin
            w_tenure_next = '0;
            if (w_pick_found) begin
                w_state_next = ST_OWN;
                w_grant_next = GRANT_ONE << w_pick_idx;
                w_ptr_next   = w_pick_idx;
            end else begin
                w_state_next = ST_PARK;
                w_grant_next = GRANT_DEF;
            end
        end else if (r_tenure != TEN_MAX) begin
            w_tenure_next = r_tenure + 1'b1;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state        <= ST_PARK;
            r_grant        <= GRANT_DEF;
            r_rr_ptr       <= DEF_IDX;
            r_tenure       <= '0;
            r_hmaster      <= DEF_IDX;
            r_hmaster_data <= DEF_IDX;
        end else if (hready) begin
            r_state        <= w_state_next;
            r_grant        <= w_grant_next;
            r_rr_ptr       <= w_ptr_next;
            r_tenure       <= w_tenure_next;
            r_hmaster      <= w_grant_idx;
            r_hmaster_data <= r_hmaster;
        end
    end

    assign hgrant       = r_grant;
    assign hmaster      = r_hmaster;
    assign hmaster_data = r_hmaster_data;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: directed scenarios then randomized
// traffic, all compared against a behavioural arbitration model.
module tb_ahb_arbiter;

    localparam int N    = 3;
    localparam int DEF  = 0;
    localparam int MAXT = 16;

    logic         hclk    = 1'b0;
    logic         hresetn = 1'b0;
    logic [N-1:0] hbusreq = '0;
    logic         hready  = 1'b1;
    logic [1:0]   hresp   = 2'b00;
    logic [N-1:0] hgrant;
    logic [1:0]   hmaster;
    logic [1:0]   hmaster_data;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: who owns the bus (or parked), edges owned, and the
    // address/data-phase owner pipeline.
    bit m_parked;
    int m_owner;
    int m_cnt;
    int m_gidx;
    int m_hm;
    int m_hmd;

    ahb_arbiter #(
        .NUM_MST     (N),
        .DEFAULT_MST (DEF),
        .MAX_TENURE  (MAXT)
    ) dut (
        .hclk         (hclk),
        .hresetn      (hresetn),
        .hbusreq      (hbusreq),
        .hready       (hready),
        .hresp        (hresp),
        .hgrant       (hgrant),
        .hmaster      (hmaster),
        .hmaster_data (hmaster_data)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_parked = 1'b1;
        m_owner  = DEF;
        m_cnt    = 0;
        m_gidx   = DEF;
        m_hm     = DEF;
        m_hmd    = DEF;
    endtask

    task automatic model_edge();
        bit found;
        bit others;
        bit retry;
        int cand;
        int winner;
        if (!hready) return;
        m_hmd = m_hm;
        m_hm  = m_gidx;
        found  = 1'b0;
        winner = 0;
        if (m_parked) begin
            for (int k = 0; k < N; k++) begin
                cand = (DEF + 1 + k) % N;
                if (!found && hbusreq[cand]) begin
                    found  = 1'b1;
                    winner = cand;
                end
            end
            if (found) begin
                m_parked = 1'b0;
                m_owner  = winner;
                m_cnt    = 0;
            end
        end else begin
            others = 1'b0;
            for (int j = 0; j < N; j++) begin
                if (j != m_owner && hbusreq[j]) others = 1'b1;
            end
            retry = (hresp == 2'b10) || (hresp == 2'b11);
            // m_cnt+1 counts this edge as the owner's latest held edge.
            if (!hbusreq[m_owner] || (others && (m_cnt + 1 >= MAXT)) || retry) begin
                for (int k = 1; k < N; k++) begin
                    cand = (m_owner + k) % N;
                    if (!found && hbusreq[cand]) begin
                        found  = 1'b1;
                        winner = cand;
                    end
                end
                m_cnt = 0;
                if (found) m_owner  = winner;
                else       m_parked = 1'b1;
            end else if (m_cnt < MAXT) begin
                m_cnt++;
            end
        end
        m_gidx = m_parked ? DEF : m_owner;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".hgrant"}, 32'(hgrant), 32'(1 << m_gidx));
        check({tag, ".hmaster"}, 32'(hmaster), 32'(m_hm));
        check({tag, ".hmaster_data"}, 32'(hmaster_data), 32'(m_hmd));
        check({tag, ".onehot"}, 32'($countones(hgrant)), 32'd1);
    endtask

    task automatic step(input string tag, input logic [N-1:0] req, input logic rdy,
                        input logic [1:0] resp);
        hbusreq = req;
        hready  = rdy;
        hresp   = resp;
        @(posedge hclk);
        model_edge();
        #1;
        compare_all(tag);
        $display("%s t=%0t req=%b rdy=%b resp=%b grant=%b hm=%0d hmd=%0d",
                 tag, $time, req, rdy, resp, hgrant, hmaster, hmaster_data);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_pulse(input string tag);
        #3;
        hresetn = 1'b0;
        #1;
        model_reset();
        check({tag, ".rst_hgrant"}, 32'(hgrant), 32'(1 << DEF));
        check({tag, ".rst_hmaster"}, 32'(hmaster), 32'(DEF));
        check({tag, ".rst_hmaster_data"}, 32'(hmaster_data), 32'(DEF));
        $display("%s t=%0t async reset grant=%b hm=%0d hmd=%0d",
                 tag, $time, hgrant, hmaster, hmaster_data);
        #1;
        hresetn = 1'b1;
    endtask

    initial begin
        int cnt;
        logic [N-1:0] rreq;
        logic [1:0]   rresp;
        logic         rrdy;

        model_reset();
        #12;
        compare_all("reset");
        hresetn = 1'b1;

        // Idle after reset: parked on the default master.
        for (int i = 0; i < 5; i++) step("idle", 3'b000, 1'b1, 2'b00);

        // 110 from PARK grants M1 after one edge; M1 drops at edge 5 -> M2.
        step("rr1", 3'b110, 1'b1, 2'b00);
        check("rr1.grant_m1", 32'(hgrant), 32'h2);
        for (int i = 0; i < 3; i++) step("rr1", 3'b110, 1'b1, 2'b00);
        step("rr1", 3'b100, 1'b1, 2'b00);
        check("rr1.grant_m2", 32'(hgrant), 32'h4);

        // Async reset while M2 owns.
        step("own2", 3'b100, 1'b1, 2'b00);
        check("own2.hmaster", 32'(hmaster), 32'h2);
        reset_pulse("rst_m2");

        // RETRY with only the owner requesting: one PARK cycle, then re-grant.
        step("retry", 3'b010, 1'b1, 2'b00);
        check("retry.granted", 32'(hgrant), 32'h2);
        step("retry", 3'b010, 1'b1, 2'b10);
        check("retry.park", 32'(hgrant), 32'h1);
        step("retry", 3'b010, 1'b1, 2'b00);
        check("retry.regrant", 32'(hgrant), 32'h2);

        // Tenure: M1 owns with M2 requesting; handover after 16 edges.
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step("tenure", 3'b110, 1'b1, 2'b00);
            cnt++;
            if (hgrant == 3'b100) break;
        end
        check("tenure.edges", 32'(cnt), 32'd16);

        // Saturated tenure with no competitor keeps the grant.
        step("sat", 3'b010, 1'b1, 2'b00);
        check("sat.m1", 32'(hgrant), 32'h2);
        for (int i = 0; i < 20; i++) step("sat", 3'b010, 1'b1, 2'b00);
        check("sat.keep", 32'(hgrant), 32'h2);
        step("sat", 3'b110, 1'b1, 2'b00);
        check("sat.handover", 32'(hgrant), 32'h4);

        // hready low for 5 cycles right after a handover freezes everything.
        for (int i = 0; i < 5; i++) step("freeze", 3'b001, 1'b0, 2'b10);
        check("freeze.hgrant", 32'(hgrant), 32'h4);
        check("freeze.hmaster", 32'(hmaster), 32'h1);
        step("thaw", 3'b100, 1'b1, 2'b00);
        check("thaw.hmaster", 32'(hmaster), 32'h2);
        check("thaw.hmaster_data", 32'(hmaster_data), 32'h1);

        // ERROR response is ignored by arbitration.
        step("error", 3'b110, 1'b1, 2'b01);
        check("error.keep", 32'(hgrant), 32'h4);

        // Randomized traffic with sticky requests and sparse resets.
        rreq = 3'b000;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) rreq = 3'($urandom_range(0, 7));
            rrdy = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       rresp = 2'b01;
                1:       rresp = 2'b10;
                2:       rresp = 2'b11;
                default: rresp = 2'b00;
            endcase
            step("rand", rreq, rrdy, rresp);
            if ($urandom_range(0, 199) == 0) reset_pulse("rand_rst");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
